pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the five-stage pipeline datapath and its hazard controller.
// The pipeline side (master) supplies stage info; the controller (slave) returns enables/selects.
interface pipe_hazard_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 32
);
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                id_is_branch;
  logic                id_br_taken;
  logic                id_is_jump;
  logic                ex_wr_en;
  logic                ex_is_load;
  logic [REG_BITS-1:0] ex_wr_num;
  logic                mm_wr_en;
  logic [REG_BITS-1:0] mm_wr_num;
  logic                wb_wr_en;
  logic [REG_BITS-1:0] wb_wr_num;
  logic [REG_BITS-1:0] ex_rs;
  logic [REG_BITS-1:0] ex_rt;
  logic                imem_busy;
  logic                dmem_busy;

  logic                pc_en;
  logic                if_id_en;
  logic                id_ex_en;
  logic                ex_mm_en;
  logic                if_id_flush;
  logic                id_ex_flush;
  logic                mm_wb_flush;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic [1:0]          br_fwd_a;
  logic [1:0]          br_fwd_b;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_br_taken, id_is_jump,
    output ex_wr_en, ex_is_load, ex_wr_num, mm_wr_en, mm_wr_num, wb_wr_en, wb_wr_num,
    output ex_rs, ex_rt, imem_busy, dmem_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mm_en, if_id_flush, id_ex_flush, mm_wb_flush,
    input  fwd_a, fwd_b, br_fwd_a, br_fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_br_taken, id_is_jump,
    input  ex_wr_en, ex_is_load, ex_wr_num, mm_wr_en, mm_wr_num, wb_wr_en, wb_wr_num,
    input  ex_rs, ex_rt, imem_busy, dmem_busy,
    output pc_en, if_id_en, id_ex_en, ex_mm_en, if_id_flush, id_ex_flush, mm_wb_flush,
    output fwd_a, fwd_b, br_fwd_a, br_fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/forwarding controller for a five-stage pipeline: load-use bubbles,
// data-memory freeze, fetch redirect flushes, operand forwarding and perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_BITS          = 5,
  parameter int LOAD_STALL_CYCLES = 1,   // legal 1..4
  parameter int CNT_W             = 32
) (
  input logic           clk,
  input logic           reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_state_q, saved_state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       saved_cnt_q, saved_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0]       eff_state;
  logic [2:0]       eff_cnt;
  logic             load_use;
  logic             redirect;
  logic             mm_valid, wb_valid, ex_alu_valid, ex_load_valid;

  logic             pc_en, if_id_en, id_ex_en, ex_mm_en;
  logic             if_id_flush, id_ex_flush, mm_wb_flush;

  logic [REG_BITS-1:0] ex_src  [2];
  logic [REG_BITS-1:0] id_src  [2];
  logic                id_uses [2];
  logic                lu_hit  [2];
  logic [1:0]          fwd_sel [2];
  logic [1:0]          br_sel  [2];

  assign ex_src[0]  = hz.ex_rs;
  assign ex_src[1]  = hz.ex_rt;
  assign id_src[0]  = hz.id_rs;
  assign id_src[1]  = hz.id_rt;
  assign id_uses[0] = hz.id_uses_rs;
  assign id_uses[1] = hz.id_uses_rt;

  // Writers to r0 never forward or create hazards: r0 is hard-wired zero.
  assign mm_valid      = hz.mm_wr_en && (hz.mm_wr_num != '0);
  assign wb_valid      = hz.wb_wr_en && (hz.wb_wr_num != '0);
  assign ex_alu_valid  = hz.ex_wr_en && !hz.ex_is_load && (hz.ex_wr_num != '0);
  assign ex_load_valid = hz.ex_wr_en &&  hz.ex_is_load && (hz.ex_wr_num != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // EX operands: the younger EX/MM result always shadows MM/WB.
      assign fwd_sel[gi] = (mm_valid && (hz.mm_wr_num == ex_src[gi])) ? 2'b01 :
                           (wb_valid && (hz.wb_wr_num == ex_src[gi])) ? 2'b10 : 2'b00;
      // Branch compare in ID can take the ALU result still in ID/EX, but not a load.
      assign br_sel[gi]  = (ex_alu_valid && (hz.ex_wr_num == id_src[gi])) ? 2'b01 :
                           (mm_valid && (hz.mm_wr_num == id_src[gi]))     ? 2'b10 :
                           (wb_valid && (hz.wb_wr_num == id_src[gi]))     ? 2'b11 : 2'b00;
      assign lu_hit[gi]  = id_uses[gi] && (hz.ex_wr_num == id_src[gi]);
    end
  endgenerate

  assign load_use = ex_load_valid && (lu_hit[0] || lu_hit[1]);
  assign redirect = hz.id_is_jump || (hz.id_is_branch && hz.id_br_taken);

  // While frozen, the behaviour on release is that of the state frozen over.
  assign eff_state = (state_q == ST_MEM_WAIT) ? saved_state_q : state_q;
  assign eff_cnt   = (state_q == ST_MEM_WAIT) ? saved_cnt_q   : cnt_q;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mm_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mm_wb_flush   = 1'b0;
    state_d       = ST_RUN;
    cnt_d         = eff_cnt;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;

    if (reset) begin
      cnt_d = 3'd0;
    end else if (hz.dmem_busy) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mm_en      = 1'b0;
      mm_wb_flush   = 1'b1;
      state_d       = ST_MEM_WAIT;
      saved_state_d = eff_state;
      saved_cnt_d   = eff_cnt;
    end else if (eff_state == ST_LU_STALL) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      cnt_d       = eff_cnt - 3'd1;
      state_d     = (eff_cnt == 3'd1) ? ST_RUN : ST_LU_STALL;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      cnt_d       = 3'(LOAD_STALL_CYCLES - 1);
      state_d     = (LOAD_STALL_CYCLES > 1) ? ST_LU_STALL : ST_RUN;
    end else if (redirect) begin
      if_id_flush = 1'b1;
    end else if (hz.imem_busy) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end

    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~pc_en};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, if_id_flush};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      saved_state_q <= ST_RUN;
      cnt_q         <= 3'd0;
      saved_cnt_q   <= 3'd0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      saved_state_q <= saved_state_d;
      cnt_q         <= cnt_d;
      saved_cnt_q   <= saved_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.if_id_en    = if_id_en;
  assign hz.id_ex_en    = id_ex_en;
  assign hz.ex_mm_en    = ex_mm_en;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.mm_wb_flush = mm_wb_flush;
  assign hz.fwd_a       = reset ? 2'b00 : fwd_sel[0];
  assign hz.fwd_b       = reset ? 2'b00 : fwd_sel[1];
  assign hz.br_fwd_a    = reset ? 2'b00 : br_sel[0];
  assign hz.br_fwd_b    = reset ? 2'b00 : br_sel[1];
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (1-cycle and 3-cycle load-use) share stimulus;
// a remaining-bubble reference model predicts each cycle's outputs, a monitor checks them.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt, id_is_branch, id_br_taken, id_is_jump;
    logic       ex_wr_en, ex_is_load;
    logic [4:0] ex_wr_num;
    logic       mm_wr_en;
    logic [4:0] mm_wr_num;
    logic       wb_wr_en;
    logic [4:0] wb_wr_num;
    logic [4:0] ex_rs, ex_rt;
    logic       imem_busy, dmem_busy;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [6:0]  ctl;   // pc_en, if_id_en, id_ex_en, ex_mm_en, if_id_flush, id_ex_flush, mm_wb_flush
    logic [3:0]  fwd;
    logic [3:0]  br;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  stim_t cur = '0;

  pipe_hazard_ctrl_if #(.REG_BITS(5), .CNT_W(4))  bus0 ();
  pipe_hazard_ctrl_if #(.REG_BITS(5), .CNT_W(32)) bus1 ();

  assign {bus0.id_rs, bus0.id_rt, bus0.id_uses_rs, bus0.id_uses_rt, bus0.id_is_branch,
          bus0.id_br_taken, bus0.id_is_jump, bus0.ex_wr_en, bus0.ex_is_load, bus0.ex_wr_num,
          bus0.mm_wr_en, bus0.mm_wr_num, bus0.wb_wr_en, bus0.wb_wr_num, bus0.ex_rs, bus0.ex_rt,
          bus0.imem_busy, bus0.dmem_busy} = cur;
  assign {bus1.id_rs, bus1.id_rt, bus1.id_uses_rs, bus1.id_uses_rt, bus1.id_is_branch,
          bus1.id_br_taken, bus1.id_is_jump, bus1.ex_wr_en, bus1.ex_is_load, bus1.ex_wr_num,
          bus1.mm_wr_en, bus1.mm_wr_num, bus1.wb_wr_en, bus1.wb_wr_num, bus1.ex_rs, bus1.ex_rt,
          bus1.imem_busy, bus1.dmem_busy} = cur;

  pipe_hazard_ctrl #(.REG_BITS(5), .LOAD_STALL_CYCLES(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .hz(bus0));
  pipe_hazard_ctrl #(.REG_BITS(5), .LOAD_STALL_CYCLES(3), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .hz(bus1));

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc_n    = 0;

  // Reference model state: bubbles still owed after the current cycle, and counters.
  int          lu_left [2] = '{0, 0};
  int          lsc     [2] = '{1, 3};
  logic [31:0] m_sc    [2] = '{32'd0, 32'd0};
  logic [31:0] m_fc    [2] = '{32'd0, 32'd0};
  logic [31:0] msk     [2] = '{32'h0000_000F, 32'hFFFF_FFFF};

  function automatic logic [1:0] ex_fwd(stim_t s, logic [4:0] src);
    if (s.mm_wr_en && s.mm_wr_num != 5'd0 && s.mm_wr_num == src) return 2'b01;
    if (s.wb_wr_en && s.wb_wr_num != 5'd0 && s.wb_wr_num == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] id_fwd(stim_t s, logic [4:0] src);
    if (s.ex_wr_en && !s.ex_is_load && s.ex_wr_num != 5'd0 && s.ex_wr_num == src) return 2'b01;
    if (s.mm_wr_en && s.mm_wr_num != 5'd0 && s.mm_wr_num == src) return 2'b10;
    if (s.wb_wr_en && s.wb_wr_num != 5'd0 && s.wb_wr_num == src) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_step(int k, stim_t s, logic rst, output exp_t e);
    logic pc, ifid, idex, exmm, f_ifid, f_idex, f_mmwb, hazard;
    e.cyc = cyc_n;
    e.sc  = m_sc[k];
    e.fc  = m_fc[k];
    if (rst) begin
      e.ctl = 7'b1111_000;
      e.fwd = 4'b0;
      e.br  = 4'b0;
      lu_left[k] = 0;
      m_sc[k] = 32'd0;
      m_fc[k] = 32'd0;
      return;
    end
    e.fwd = {ex_fwd(s, s.ex_rs), ex_fwd(s, s.ex_rt)};
    e.br  = {id_fwd(s, s.id_rs), id_fwd(s, s.id_rt)};
    hazard = s.ex_is_load && s.ex_wr_en && s.ex_wr_num != 5'd0 &&
             ((s.id_uses_rs && s.ex_wr_num == s.id_rs) || (s.id_uses_rt && s.ex_wr_num == s.id_rt));
    {pc, ifid, idex, exmm, f_ifid, f_idex, f_mmwb} = 7'b1111_000;
    if (s.dmem_busy) begin
      {pc, ifid, idex, exmm, f_mmwb} = 5'b0000_1;
    end else if (lu_left[k] > 0) begin
      {pc, ifid, f_idex} = 3'b001;
      lu_left[k] = lu_left[k] - 1;
    end else if (hazard) begin
      {pc, ifid, f_idex} = 3'b001;
      lu_left[k] = lsc[k] - 1;
    end else if (s.id_is_jump || (s.id_is_branch && s.id_br_taken)) begin
      f_ifid = 1'b1;
    end else if (s.imem_busy) begin
      pc = 1'b0;
      f_ifid = 1'b1;
    end
    e.ctl = {pc, ifid, idex, exmm, f_ifid, f_idex, f_mmwb};
    m_sc[k] = (m_sc[k] + (pc ? 32'd0 : 32'd1)) & msk[k];
    m_fc[k] = (m_fc[k] + (f_ifid ? 32'd1 : 32'd0)) & msk[k];
  endtask

  task automatic drive(stim_t s, logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    cur   = s;
    model_step(0, s, rst, e);
    q0.push_back(e);
    model_step(1, s, rst, e);
    q1.push_back(e);
    cyc_n++;
  endtask

  task automatic chk(string name, int k, int cyc, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: the controller presents a full output set every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("ctl",   0, e.cyc, {25'd0, bus0.pc_en, bus0.if_id_en, bus0.id_ex_en, bus0.ex_mm_en,
                              bus0.if_id_flush, bus0.id_ex_flush, bus0.mm_wb_flush}, {25'd0, e.ctl});
      chk("fwd",   0, e.cyc, {28'd0, bus0.fwd_a, bus0.fwd_b}, {28'd0, e.fwd});
      chk("brfwd", 0, e.cyc, {28'd0, bus0.br_fwd_a, bus0.br_fwd_b}, {28'd0, e.br});
      chk("stall_cnt", 0, e.cyc, {28'd0, bus0.stall_cnt}, e.sc);
      chk("flush_cnt", 0, e.cyc, {28'd0, bus0.flush_cnt}, e.fc);
      $display("cyc %0d dut0 ctl=%b fwd=%h br=%h sc=%0d fc=%0d", e.cyc, e.ctl, e.fwd, e.br, e.sc, e.fc);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("ctl",   1, e.cyc, {25'd0, bus1.pc_en, bus1.if_id_en, bus1.id_ex_en, bus1.ex_mm_en,
                              bus1.if_id_flush, bus1.id_ex_flush, bus1.mm_wb_flush}, {25'd0, e.ctl});
      chk("fwd",   1, e.cyc, {28'd0, bus1.fwd_a, bus1.fwd_b}, {28'd0, e.fwd});
      chk("brfwd", 1, e.cyc, {28'd0, bus1.br_fwd_a, bus1.br_fwd_b}, {28'd0, e.br});
      chk("stall_cnt", 1, e.cyc, bus1.stall_cnt, e.sc);
      chk("flush_cnt", 1, e.cyc, bus1.flush_cnt, e.fc);
      $display("cyc %0d dut1 ctl=%b fwd=%h br=%h sc=%0d fc=%0d", e.cyc, e.ctl, e.fwd, e.br, e.sc, e.fc);
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_rs        = 5'($urandom_range(0, 7));
    s.id_rt        = 5'($urandom_range(0, 7));
    s.id_uses_rs   = 1'($urandom_range(0, 1));
    s.id_uses_rt   = 1'($urandom_range(0, 1));
    s.id_is_branch = ($urandom_range(0, 3) == 0);
    s.id_br_taken  = 1'($urandom_range(0, 1));
    s.id_is_jump   = ($urandom_range(0, 7) == 0);
    s.ex_wr_en     = 1'($urandom_range(0, 1));
    s.ex_is_load   = 1'($urandom_range(0, 1));
    s.ex_wr_num    = 5'($urandom_range(0, 7));
    s.mm_wr_en     = 1'($urandom_range(0, 1));
    s.mm_wr_num    = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    s.wb_wr_en     = 1'($urandom_range(0, 1));
    s.wb_wr_num    = 5'($urandom_range(0, 7));
    s.ex_rs        = 5'($urandom_range(0, 7));
    s.ex_rt        = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    s.imem_busy    = ($urandom_range(0, 3) == 0);
    s.dmem_busy    = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    stim_t idle, s, haz;
    int    drain;
    idle = '0;
    haz = idle;
    haz.ex_is_load = 1'b1;
    haz.ex_wr_en   = 1'b1;
    haz.ex_wr_num  = 5'd8;
    haz.id_uses_rs = 1'b1;
    haz.id_rs      = 5'd8;

    repeat (3) drive(idle, 1'b1);
    // Single load-use bubble (dut0) versus three bubbles (dut1).
    drive(haz, 1'b0);
    repeat (5) drive(idle, 1'b0);
    // Freeze while dut1 still owes one bubble.
    drive(haz, 1'b0);
    drive(idle, 1'b0);
    s = idle; s.dmem_busy = 1'b1;
    repeat (4) drive(s, 1'b0);
    repeat (3) drive(idle, 1'b0);
    // Forwarding: EX/MM shadows MM/WB, then r0 never forwards.
    s = idle; s.mm_wr_en = 1'b1; s.mm_wr_num = 5'd5; s.wb_wr_en = 1'b1; s.wb_wr_num = 5'd5; s.ex_rs = 5'd5;
    drive(s, 1'b0);
    s.mm_wr_num = 5'd0;
    drive(s, 1'b0);
    s.wb_wr_num = 5'd0; s.ex_rs = 5'd0;
    drive(s, 1'b0);
    // Taken branch during imem_busy, then the same with a load-use hazard.
    s = idle; s.id_is_branch = 1'b1; s.id_br_taken = 1'b1; s.imem_busy = 1'b1;
    drive(s, 1'b0);
    s.ex_is_load = 1'b1; s.ex_wr_en = 1'b1; s.ex_wr_num = 5'd8; s.id_uses_rs = 1'b1; s.id_rs = 5'd8;
    drive(s, 1'b0);
    repeat (3) drive(idle, 1'b0);
    // Reset in the middle of dut1's load-use stall.
    drive(haz, 1'b0);
    drive(idle, 1'b0);
    drive(idle, 1'b1);
    repeat (3) drive(idle, 1'b0);
    // Fetch stalls long enough to wrap the 4-bit counter of dut0.
    s = idle; s.imem_busy = 1'b1;
    repeat (20) drive(s, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive(rand_stim(), ($urandom_range(0, 199) == 0));
    end
    drive(idle, 1'b0);

    drain = 0;
    while ((q0.size() > 0 || q1.size() > 0) && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    @(posedge clk);
    n_assert++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left expected 0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
